// File: rtl/id_issue_stage.sv
// id_issue_stage: decode / issue stage sitting between the IF/ID register and EX.
//
// Decodes the IF/ID instruction, reads the register file with WB write-through,
// picks forwarding selects for EX, interlocks on load-use (and on any EX/MEM
// match when forwarding is compiled out), resolves branches and jumps in ID,
// and registers everything into the ID/EX boundary.
//
// Ports
//   clk, clr                  clock, asynchronous active-high reset
//   if_valid/if_inst/if_pc4   IF/ID contents
//   id_ready                  ID consumes the IF/ID instruction this cycle
//   flush, pcsource, bpc, jpc redirect to IF on a taken branch or jump
//   ex_*, mem_*               producer info from EX and MEM (hazard/forwarding)
//   wb_rd/wb_wreg/wb_data     register file write port
//   ex_ready                  EX accepts the ID/EX contents
//   idex_*                    registered ID/EX boundary
module id_issue_stage #(
    parameter int XLEN     = 32,
    parameter int RA_W     = 5,
    parameter int LOAD_LAT = 1,
    parameter int FWD_EN   = 1
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            if_valid,
    input  logic [31:0]     if_inst,
    input  logic [XLEN-1:0] if_pc4,
    output logic            id_ready,
    output logic            flush,
    output logic [1:0]      pcsource,
    output logic [XLEN-1:0] bpc,
    output logic [XLEN-1:0] jpc,
    input  logic [RA_W-1:0] ex_rd,
    input  logic            ex_wreg,
    input  logic            ex_m2reg,
    input  logic [XLEN-1:0] ex_fwd,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            mem_wreg,
    input  logic [XLEN-1:0] mem_fwd,
    input  logic [RA_W-1:0] wb_rd,
    input  logic            wb_wreg,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_ready,
    output logic            idex_valid,
    output logic [XLEN-1:0] idex_a,
    output logic [XLEN-1:0] idex_b,
    output logic [XLEN-1:0] idex_imm,
    output logic [1:0]      idex_asel,
    output logic [1:0]      idex_bsel,
    output logic [2:0]      idex_aluc,
    output logic            idex_aluimm,
    output logic            idex_wreg,
    output logic            idex_m2reg,
    output logic            idex_wmem,
    output logic [RA_W-1:0] idex_rn
);

    localparam logic [1:0] LAT_M1 = 2'(LOAD_LAT - 1);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] imm;
        logic [1:0]      asel;
        logic [1:0]      bsel;
        logic [2:0]      aluc;
        logic            aluimm;
        logic            wreg;
        logic            m2reg;
        logic            wmem;
        logic [RA_W-1:0] rn;
    } idex_t;

    // ---------------- field extraction ----------------
    logic [5:0]      op;
    logic [5:0]      func;
    logic [15:0]     imm16;
    logic [RA_W-1:0] f_rd, f_rs, f_rt;

    assign op    = if_inst[31:26];
    assign func  = if_inst[25:20];
    assign imm16 = if_inst[25:10];
    assign f_rd  = RA_W'(if_inst[14:10]);
    assign f_rs  = RA_W'(if_inst[9:5]);
    assign f_rt  = RA_W'(if_inst[4:0]);

    // ---------------- decode ----------------
    logic            use_rs, use_rt, wr, m2reg, wmem, aluimm, sext;
    logic            is_beq, is_bne, is_j;
    logic [2:0]      aluc;
    logic [RA_W-1:0] dest;

    always_comb begin
        use_rs = 1'b0;
        use_rt = 1'b0;
        wr     = 1'b0;
        m2reg  = 1'b0;
        wmem   = 1'b0;
        aluimm = 1'b0;
        sext   = 1'b1;
        is_beq = 1'b0;
        is_bne = 1'b0;
        is_j   = 1'b0;
        aluc   = 3'b000;
        dest   = '0;
        case (op)
            6'h00: begin use_rs = 1'b1; use_rt = 1'b1; wr = 1'b1; dest = f_rd; aluc = func[2:0]; end
            6'h01: begin use_rs = 1'b1; wr = 1'b1; dest = f_rt; aluimm = 1'b1; end
            6'h02: begin use_rs = 1'b1; wr = 1'b1; dest = f_rt; aluimm = 1'b1; sext = 1'b0; aluc = 3'b011; end
            6'h03: begin use_rs = 1'b1; wr = 1'b1; dest = f_rt; aluimm = 1'b1; m2reg = 1'b1; end
            6'h04: begin use_rs = 1'b1; use_rt = 1'b1; aluimm = 1'b1; wmem = 1'b1; end
            6'h05: begin use_rs = 1'b1; use_rt = 1'b1; is_beq = 1'b1; aluc = 3'b001; end
            6'h06: begin use_rs = 1'b1; use_rt = 1'b1; is_bne = 1'b1; aluc = 3'b001; end
            6'h07: is_j = 1'b1;
            default: ;
        endcase
    end

    logic [XLEN-1:0] imm;
    assign imm = sext ? {{(XLEN-16){imm16[15]}}, imm16} : {{(XLEN-16){1'b0}}, imm16};
    assign bpc = if_pc4 + {imm[XLEN-3:0], 2'b00};
    assign jpc = {if_pc4[XLEN-1:28], if_inst[25:0], 2'b00};

    // Unused source slots are treated as r0 so they never match a producer.
    logic [RA_W-1:0] src_a, src_b;
    assign src_a = use_rs ? f_rs : '0;
    assign src_b = use_rt ? f_rt : '0;

    // ---------------- register file ----------------
    logic [XLEN-1:0] rf [2**RA_W];

    always_ff @(posedge clk) begin
        if (wb_wreg && wb_rd != '0)
            rf[wb_rd] <= wb_data;
    end

    logic [XLEN-1:0] rf_a, rf_b;
    always_comb begin
        rf_a = rf[src_a];
        if (src_a == '0)                        rf_a = '0;
        else if (wb_wreg && wb_rd == src_a)     rf_a = wb_data;
        rf_b = rf[src_b];
        if (src_b == '0)                        rf_b = '0;
        else if (wb_wreg && wb_rd == src_b)     rf_b = wb_data;
    end

    // ---------------- producer matching ----------------
    logic a_ex, a_mem, a_ld, b_ex, b_mem, b_ld;
    assign a_ex  = (src_a != '0) && ex_wreg && (ex_rd == src_a) && !ex_m2reg;
    assign a_mem = (src_a != '0) && mem_wreg && (mem_rd == src_a);
    assign a_ld  = (src_a != '0) && ex_m2reg && (ex_rd == src_a);
    assign b_ex  = (src_b != '0) && ex_wreg && (ex_rd == src_b) && !ex_m2reg;
    assign b_mem = (src_b != '0) && mem_wreg && (mem_rd == src_b);
    assign b_ld  = (src_b != '0) && ex_m2reg && (ex_rd == src_b);

    logic [1:0] asel_raw, bsel_raw;
    assign asel_raw = a_ex ? 2'b01 : (a_mem ? 2'b10 : 2'b00);
    assign bsel_raw = b_ex ? 2'b01 : (b_mem ? 2'b10 : 2'b00);

    // Branch compare always uses the bypass values, so branches only wait on loads.
    logic [XLEN-1:0] cmp_a, cmp_b;
    assign cmp_a = a_ex ? ex_fwd : (a_mem ? mem_fwd : rf_a);
    assign cmp_b = b_ex ? ex_fwd : (b_mem ? mem_fwd : rf_b);

    // ---------------- interlock ----------------
    logic [1:0] cnt;
    logic       hz_ld, hz_nf, stall, ld, accept, taken;

    assign hz_ld = if_valid && (a_ld || b_ld);
    assign hz_nf = (FWD_EN == 0) && if_valid && !(is_beq || is_bne || is_j)
                   && (a_ex || a_mem || b_ex || b_mem);
    assign stall = (cnt != 2'd0) || hz_ld || hz_nf;

    // The first stall cycle comes straight from the comparator; the counter
    // covers the remaining LOAD_LAT-1 and re-arms naturally once it hits zero.
    always_ff @(posedge clk or posedge clr) begin
        if (clr)                cnt <= 2'd0;
        else if (cnt != 2'd0)   cnt <= cnt - 2'd1;
        else if (hz_ld)         cnt <= LAT_M1;
    end

    assign ld       = ex_ready || !idex_valid;
    assign id_ready = !stall && ld;
    assign accept   = if_valid && id_ready;
    assign taken    = (is_beq && cmp_a == cmp_b) || (is_bne && cmp_a != cmp_b) || is_j;
    assign flush    = accept && taken;
    assign pcsource = flush ? (is_j ? 2'b10 : 2'b01) : 2'b00;

    // ---------------- ID/EX register ----------------
    idex_t d, q;

    always_comb begin
        d        = '0;
        d.valid  = 1'b1;
        d.a      = rf_a;
        d.b      = rf_b;
        d.imm    = imm;
        d.asel   = (FWD_EN != 0) ? asel_raw : 2'b00;
        d.bsel   = (FWD_EN != 0) ? bsel_raw : 2'b00;
        d.aluc   = aluc;
        d.aluimm = aluimm;
        d.wreg   = wr && (dest != '0);
        d.m2reg  = m2reg;
        d.wmem   = wmem;
        d.rn     = dest;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr)        q <= '0;
        else if (ld)    q <= accept ? d : '0;
    end

    assign idex_valid  = q.valid;
    assign idex_a      = q.a;
    assign idex_b      = q.b;
    assign idex_imm    = q.imm;
    assign idex_asel   = q.asel;
    assign idex_bsel   = q.bsel;
    assign idex_aluc   = q.aluc;
    assign idex_aluimm = q.aluimm;
    assign idex_wreg   = q.wreg;
    assign idex_m2reg  = q.m2reg;
    assign idex_wmem   = q.wmem;
    assign idex_rn     = q.rn;

endmodule

// File: tb/tb_id_issue_stage.sv
// Bench for id_issue_stage: main instance LOAD_LAT=2 with forwarding, second
// instance with forwarding compiled out sharing the same stimulus.
module tb_id_issue_stage;

    logic        clk = 1'b0;
    logic        clr;
    logic        if_valid;
    logic [31:0] if_inst, if_pc4;
    logic [4:0]  ex_rd, mem_rd, wb_rd;
    logic        ex_wreg, ex_m2reg, mem_wreg, wb_wreg, ex_ready;
    logic [31:0] ex_fwd, mem_fwd, wb_data;

    logic        id_ready, flush, idex_valid, idex_aluimm, idex_wreg, idex_m2reg, idex_wmem;
    logic [1:0]  pcsource, idex_asel, idex_bsel;
    logic [31:0] bpc, jpc, idex_a, idex_b, idex_imm;
    logic [2:0]  idex_aluc;
    logic [4:0]  idex_rn;

    logic        b_id_ready, b_flush, b_idex_valid, b_idex_aluimm, b_idex_wreg, b_idex_m2reg, b_idex_wmem;
    logic [1:0]  b_pcsource, b_idex_asel, b_idex_bsel;
    logic [31:0] b_bpc, b_jpc, b_idex_a, b_idex_b, b_idex_imm;
    logic [2:0]  b_idex_aluc;
    logic [4:0]  b_idex_rn;

    always #5 clk = ~clk;

    id_issue_stage #(.XLEN(32), .RA_W(5), .LOAD_LAT(2), .FWD_EN(1)) dut (
        .clk(clk), .clr(clr), .if_valid(if_valid), .if_inst(if_inst), .if_pc4(if_pc4),
        .id_ready(id_ready), .flush(flush), .pcsource(pcsource), .bpc(bpc), .jpc(jpc),
        .ex_rd(ex_rd), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_fwd(ex_fwd),
        .mem_rd(mem_rd), .mem_wreg(mem_wreg), .mem_fwd(mem_fwd),
        .wb_rd(wb_rd), .wb_wreg(wb_wreg), .wb_data(wb_data), .ex_ready(ex_ready),
        .idex_valid(idex_valid), .idex_a(idex_a), .idex_b(idex_b), .idex_imm(idex_imm),
        .idex_asel(idex_asel), .idex_bsel(idex_bsel), .idex_aluc(idex_aluc),
        .idex_aluimm(idex_aluimm), .idex_wreg(idex_wreg), .idex_m2reg(idex_m2reg),
        .idex_wmem(idex_wmem), .idex_rn(idex_rn));

    id_issue_stage #(.XLEN(32), .RA_W(5), .LOAD_LAT(1), .FWD_EN(0)) dut_nf (
        .clk(clk), .clr(clr), .if_valid(if_valid), .if_inst(if_inst), .if_pc4(if_pc4),
        .id_ready(b_id_ready), .flush(b_flush), .pcsource(b_pcsource), .bpc(b_bpc), .jpc(b_jpc),
        .ex_rd(ex_rd), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_fwd(ex_fwd),
        .mem_rd(mem_rd), .mem_wreg(mem_wreg), .mem_fwd(mem_fwd),
        .wb_rd(wb_rd), .wb_wreg(wb_wreg), .wb_data(wb_data), .ex_ready(ex_ready),
        .idex_valid(b_idex_valid), .idex_a(b_idex_a), .idex_b(b_idex_b), .idex_imm(b_idex_imm),
        .idex_asel(b_idex_asel), .idex_bsel(b_idex_bsel), .idex_aluc(b_idex_aluc),
        .idex_aluimm(b_idex_aluimm), .idex_wreg(b_idex_wreg), .idex_m2reg(b_idex_m2reg),
        .idex_wmem(b_idex_wmem), .idex_rn(b_idex_rn));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] r_ins(input logic [5:0] fn, input logic [4:0] rd, rs, rt);
        return {6'h00, fn, 5'b0, rd, rs, rt};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [15:0] im, input logic [4:0] rs, rt);
        return {op, im, rs, rt};
    endfunction

    task automatic idle();
        if_valid = 1'b0; if_inst = 32'h0; if_pc4 = 32'h0;
        ex_rd = 5'd0; ex_wreg = 1'b0; ex_m2reg = 1'b0; ex_fwd = 32'h0;
        mem_rd = 5'd0; mem_wreg = 1'b0; mem_fwd = 32'h0;
        wb_rd = 5'd0; wb_wreg = 1'b0; wb_data = 32'h0;
        ex_ready = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [31:0] inst, pc4;
        logic [4:0]  exrd;  logic exw, exm;
        logic [4:0]  memrd; logic memw;
        logic [31:0] exf, memf;
        logic [1:0]  asel, bsel;
        logic [31:0] imm;
        logic [2:0]  aluc;
        logic        aluimm, wreg, m2reg, wmem;
        logic [4:0]  rn;
        logic        fl;
        logic [1:0]  ps;
        logic [31:0] tgt;
    } vec_t;

    vec_t tv [12];

    initial begin
        //        inst                            pc4            exrd exw exm memrd memw exf    memf   asel  bsel  imm            aluc aimm wr m2 wm rn   fl ps    tgt
        tv[0]  = '{i_ins(6'h01,16'hFFFC,5'd0,5'd1), 32'h0,        5'd0,0,0, 5'd0,0, 32'h0, 32'h0, 2'b00,2'b00,32'hFFFFFFFC,3'd0,1,1,0,0,5'd1, 0,2'b00,32'h0};
        tv[1]  = '{r_ins(6'h00,5'd3,5'd1,5'd2),     32'h0,        5'd1,1,0, 5'd0,0, 32'h0, 32'h0, 2'b01,2'b00,32'h00000003,3'd0,0,1,0,0,5'd3, 0,2'b00,32'h0};
        tv[2]  = '{r_ins(6'h02,5'd4,5'd2,5'd6),     32'h0,        5'd6,1,0, 5'd6,1, 32'h0, 32'h0, 2'b00,2'b01,32'h00000804,3'd2,0,1,0,0,5'd4, 0,2'b00,32'h0};
        tv[3]  = '{i_ins(6'h02,16'h8001,5'd1,5'd7), 32'h0,        5'd0,0,0, 5'd0,0, 32'h0, 32'h0, 2'b00,2'b00,32'h00008001,3'd3,1,1,0,0,5'd7, 0,2'b00,32'h0};
        tv[4]  = '{i_ins(6'h01,16'h0005,5'd1,5'd0), 32'h0,        5'd0,0,0, 5'd0,0, 32'h0, 32'h0, 2'b00,2'b00,32'h00000005,3'd0,1,0,0,0,5'd0, 0,2'b00,32'h0};
        tv[5]  = '{i_ins(6'h04,16'h0010,5'd1,5'd2), 32'h0,        5'd0,0,0, 5'd2,1, 32'h0, 32'h0, 2'b00,2'b10,32'h00000010,3'd0,1,0,0,1,5'd0, 0,2'b00,32'h0};
        tv[6]  = '{i_ins(6'h03,16'hFFF0,5'd1,5'd9), 32'h0,        5'd0,0,0, 5'd0,0, 32'h0, 32'h0, 2'b00,2'b00,32'hFFFFFFF0,3'd0,1,1,1,0,5'd9, 0,2'b00,32'h0};
        tv[7]  = '{32'hFC000000,                    32'h0,        5'd0,0,0, 5'd0,0, 32'h0, 32'h0, 2'b00,2'b00,32'h00000000,3'd0,0,0,0,0,5'd0, 0,2'b00,32'h0};
        tv[8]  = '{{6'h07,26'h0123456},             32'h10000100, 5'd0,0,0, 5'd0,0, 32'h0, 32'h0, 2'b00,2'b00,32'h0000048D,3'd0,0,0,0,0,5'd0, 1,2'b10,32'h1048D158};
        tv[9]  = '{i_ins(6'h05,16'h0003,5'd1,5'd2), 32'h00000100, 5'd2,1,0, 5'd1,1, 32'h55,32'h55, 2'b10,2'b01,32'h00000003,3'd1,0,0,0,0,5'd0, 1,2'b01,32'h0000010C};
        tv[10] = '{i_ins(6'h06,16'h0003,5'd1,5'd2), 32'h00000100, 5'd2,1,0, 5'd1,1, 32'h55,32'h55, 2'b10,2'b01,32'h00000003,3'd1,0,0,0,0,5'd0, 0,2'b00,32'h0};
        tv[11] = '{i_ins(6'h06,16'hFFFF,5'd1,5'd2), 32'h00000100, 5'd2,1,0, 5'd1,1, 32'h55,32'h66, 2'b10,2'b01,32'hFFFFFFFF,3'd1,0,0,0,0,5'd0, 1,2'b01,32'h000000FC};

        // ---------------- reset ----------------
        idle();
        clr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", idex_valid, 0);
        chk("rst_imm", idex_imm, 0);
        clr = 1'b0;
        @(negedge clk);
        chk("rst_ready", id_ready, 1);
        chk("rst_flush", flush, 0);
        chk("rst_pcsource", pcsource, 0);
        tick();

        // ---------------- table ----------------
        for (int i = 0; i < 12; i++) begin
            idle();
            if_valid = 1'b1; if_inst = tv[i].inst; if_pc4 = tv[i].pc4;
            ex_rd = tv[i].exrd; ex_wreg = tv[i].exw; ex_m2reg = tv[i].exm; ex_fwd = tv[i].exf;
            mem_rd = tv[i].memrd; mem_wreg = tv[i].memw; mem_fwd = tv[i].memf;
            @(negedge clk);
            chk($sformatf("v%0d_ready", i), id_ready, 1);
            chk($sformatf("v%0d_flush", i), flush, tv[i].fl);
            chk($sformatf("v%0d_pcsource", i), pcsource, tv[i].ps);
            if (tv[i].ps == 2'b01) chk($sformatf("v%0d_bpc", i), bpc, tv[i].tgt);
            if (tv[i].ps == 2'b10) chk($sformatf("v%0d_jpc", i), jpc, tv[i].tgt);
            tick();
            chk($sformatf("v%0d_valid", i), idex_valid, 1);
            chk($sformatf("v%0d_asel", i), idex_asel, tv[i].asel);
            chk($sformatf("v%0d_bsel", i), idex_bsel, tv[i].bsel);
            chk($sformatf("v%0d_imm", i), idex_imm, tv[i].imm);
            chk($sformatf("v%0d_aluc", i), idex_aluc, tv[i].aluc);
            chk($sformatf("v%0d_aluimm", i), idex_aluimm, tv[i].aluimm);
            chk($sformatf("v%0d_wreg", i), idex_wreg, tv[i].wreg);
            chk($sformatf("v%0d_m2reg", i), idex_m2reg, tv[i].m2reg);
            chk($sformatf("v%0d_wmem", i), idex_wmem, tv[i].wmem);
            chk($sformatf("v%0d_rn", i), idex_rn, tv[i].rn);
        end
        // flush must have been a single-cycle pulse
        idle();
        @(negedge clk);
        chk("flush_pulse_end", flush, 0);
        tick();
        chk("bubble_after_table", idex_valid, 0);

        // ---------------- load-use, LOAD_LAT=2 ----------------
        idle();
        if_valid = 1'b1; if_inst = r_ins(6'h00, 5'd3, 5'd2, 5'd0);
        ex_rd = 5'd2; ex_wreg = 1'b1; ex_m2reg = 1'b1;
        @(negedge clk);
        chk("lu_ready_c1", id_ready, 0);
        tick();
        chk("lu_bubble_c1", idex_valid, 0);
        ex_rd = 5'd0; ex_wreg = 1'b0; ex_m2reg = 1'b0;
        mem_rd = 5'd2; mem_wreg = 1'b1;
        @(negedge clk);
        chk("lu_ready_c2", id_ready, 0);
        tick();
        chk("lu_bubble_c2", idex_valid, 0);
        @(negedge clk);
        chk("lu_ready_c3", id_ready, 1);
        tick();
        chk("lu_issue_valid", idex_valid, 1);
        chk("lu_issue_asel", idex_asel, 2'b10);
        chk("lu_issue_rn", idex_rn, 3);

        // ---------------- stall beats taken branch ----------------
        idle();
        if_valid = 1'b1; if_inst = i_ins(6'h05, 16'h0001, 5'd1, 5'd1); if_pc4 = 32'h200;
        ex_rd = 5'd1; ex_wreg = 1'b1; ex_m2reg = 1'b1;
        @(negedge clk);
        chk("brst_ready", id_ready, 0);
        chk("brst_flush", flush, 0);
        tick();
        ex_rd = 5'd0; ex_wreg = 1'b0; ex_m2reg = 1'b0;
        @(negedge clk);
        chk("brst_flush_c2", flush, 0);
        tick();
        @(negedge clk);
        chk("brst_flush_go", flush, 1);
        chk("brst_bpc", bpc, 32'h204);
        tick();
        chk("brst_issue", idex_valid, 1);

        // ---------------- ex_ready backpressure ----------------
        idle();
        if_valid = 1'b1; if_inst = i_ins(6'h01, 16'h0011, 5'd0, 5'd1);
        tick();
        if_inst = i_ins(6'h02, 16'h8001, 5'd0, 5'd7);
        ex_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("bp_ready_c%0d", c), id_ready, 0);
            tick();
            chk($sformatf("bp_valid_c%0d", c), idex_valid, 1);
            chk($sformatf("bp_imm_c%0d", c), idex_imm, 32'h11);
            chk($sformatf("bp_rn_c%0d", c), idex_rn, 1);
        end
        ex_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_release", id_ready, 1);
        tick();
        chk("bp_next_rn", idex_rn, 7);
        chk("bp_next_imm", idex_imm, 32'h8001);
        if_valid = 1'b0;
        tick();
        chk("bp_no_dup", idex_valid, 0);

        // ---------------- reset mid-stall ----------------
        idle();
        if_valid = 1'b1; if_inst = i_ins(6'h01, 16'h0022, 5'd0, 5'd4);
        tick();
        ex_ready = 1'b0;
        if_inst = r_ins(6'h00, 5'd3, 5'd2, 5'd0);
        ex_rd = 5'd2; ex_wreg = 1'b1; ex_m2reg = 1'b1;
        tick();
        chk("ms_ready_before", id_ready, 0);
        chk("ms_valid_before", idex_valid, 1);
        clr = 1'b1;
        #1;
        chk("ms_async_valid", idex_valid, 0);
        clr = 1'b0;
        idle();
        if_valid = 1'b1; if_inst = i_ins(6'h01, 16'h0001, 5'd0, 5'd6);
        #1;
        chk("ms_ready_after", id_ready, 1);
        chk("ms_imm_zero", idex_imm, 0);
        chk("ms_rn_zero", idex_rn, 0);
        chk("ms_wreg_zero", idex_wreg, 0);
        tick();

        // ---------------- register file write-through ----------------
        idle();
        if_valid = 1'b1; if_inst = r_ins(6'h00, 5'd3, 5'd5, 5'd0);
        wb_rd = 5'd5; wb_wreg = 1'b1; wb_data = 32'hA5;
        tick();
        chk("wt_a_r5", idex_a, 32'hA5);
        chk("wt_b_r0", idex_b, 0);
        if_inst = r_ins(6'h00, 5'd3, 5'd0, 5'd5);
        wb_rd = 5'd0; wb_wreg = 1'b1; wb_data = 32'h7;
        tick();
        chk("wt_r0_during_write", idex_a, 0);
        chk("wt_r5_stored", idex_b, 32'hA5);
        wb_wreg = 1'b0;
        if_inst = r_ins(6'h00, 5'd3, 5'd0, 5'd0);
        tick();
        chk("wt_r0_after_write", idex_a, 0);

        // ---------------- no-forwarding build ----------------
        idle();
        if_valid = 1'b1; if_inst = r_ins(6'h00, 5'd3, 5'd1, 5'd0);
        ex_rd = 5'd1; ex_wreg = 1'b1;
        @(negedge clk);
        chk("nf_ex_stall", b_id_ready, 0);
        chk("fwd_ex_nostall", id_ready, 1);
        tick();
        chk("nf_bubble", b_idex_valid, 0);
        ex_rd = 5'd0; ex_wreg = 1'b0;
        mem_rd = 5'd1; mem_wreg = 1'b1;
        @(negedge clk);
        chk("nf_mem_stall", b_id_ready, 0);
        tick();
        mem_rd = 5'd0; mem_wreg = 1'b0;
        @(negedge clk);
        chk("nf_clear", b_id_ready, 1);
        tick();
        chk("nf_issue", b_idex_valid, 1);
        chk("nf_asel", b_idex_asel, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
